// File: rtl/ieee_to_binary.sv
// rtl/ieee_to_binary.sv - IEEE-754 single to unsigned fixed-point magnitude, one-cycle registered
// Optional IEEE_TO_BINARY_SATURATE_EN clamps overflowed magnitudes to all ones.
module ieee_to_binary #(
    parameter int INT_W  = 5,
    parameter int FRAC_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in,
    input  logic              in_valid,
    output logic [INT_W-1:0]  out_digit,
    output logic [FRAC_W-1:0] out_float,
    output logic              out_sign,
    output logic              out_ovf,
    output logic              out_nan,
    output logic              out_valid
);
    localparam int W  = INT_W + FRAC_W;
    localparam int MW = W + 24;

    logic [7:0]        exp_w;
    logic [22:0]       man_w;
    int                e_val;
    int                sh_val;
    logic [MW-1:0]     mag_w;
    logic [W-1:0]      fix_w;

    logic [INT_W-1:0]  out_digit_d, out_digit_q;
    logic [FRAC_W-1:0] out_float_d, out_float_q;
    logic              out_sign_d, out_sign_q;
    logic              out_ovf_d, out_ovf_q;
    logic              out_nan_d, out_nan_q;
    logic              out_valid_q;

    // Barrel shift places 1.m so that bit 24 of mag_w carries weight 2^-FRAC_W.
    always_comb begin
        exp_w  = in[30:23];
        man_w  = in[22:0];
        e_val  = int'(exp_w) - 127;
        sh_val = e_val + FRAC_W + 1;
        mag_w  = '0;
        if (e_val >= -(FRAC_W + 1) && e_val <= INT_W + 23) begin
            mag_w = {{W{1'b0}}, 1'b1, man_w} << sh_val;
        end
        fix_w = mag_w[MW-1:24];
    end

    always_comb begin
        out_sign_d  = in[31];
        out_ovf_d   = 1'b0;
        out_nan_d   = 1'b0;
        out_digit_d = '0;
        out_float_d = '0;
        if (exp_w == 8'd0) begin
            out_ovf_d = 1'b0;
        end else if (exp_w == 8'hFF) begin
            out_nan_d = (man_w != 23'd0);
            out_ovf_d = (man_w == 23'd0);
        end else begin
            out_ovf_d   = (e_val >= INT_W);
            out_digit_d = fix_w[W-1:FRAC_W];
            out_float_d = fix_w[FRAC_W-1:0];
        end
`ifdef IEEE_TO_BINARY_SATURATE_EN
        if (out_ovf_d) begin
            out_digit_d = '1;
            out_float_d = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_digit_q <= '0;
            out_float_q <= '0;
            out_sign_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_nan_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_digit_q <= out_digit_d;
                out_float_q <= out_float_d;
                out_sign_q  <= out_sign_d;
                out_ovf_q   <= out_ovf_d;
                out_nan_q   <= out_nan_d;
            end
        end
    end

    assign out_digit = out_digit_q;
    assign out_float = out_float_q;
    assign out_sign  = out_sign_q;
    assign out_ovf   = out_ovf_q;
    assign out_nan   = out_nan_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_ieee_to_binary.sv
// tb/tb_ieee_to_binary.sv - scoreboard bench for ieee_to_binary
module tb_ieee_to_binary;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_r = '0;
    logic        in_valid = 1'b0;
    logic [4:0]  out_digit, out_float;
    logic        out_sign, out_ovf, out_nan, out_valid;

    typedef struct packed {
        logic [4:0] d;
        logic [4:0] f;
        logic       s;
        logic       o;
        logic       n;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    ieee_to_binary #(.INT_W(5), .FRAC_W(5)) dut (
        .clk(clk), .rst(rst), .in(in_r), .in_valid(in_valid),
        .out_digit(out_digit), .out_float(out_float), .out_sign(out_sign),
        .out_ovf(out_ovf), .out_nan(out_nan), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] d, input logic [4:0] f,
                                input logic s, input logic o, input logic n);
        exp_t e;
        e = '{d: d, f: f, s: s, o: o, n: n};
`ifdef IEEE_TO_BINARY_SATURATE_EN
        if (o) begin
            e.d = 5'h1F;
            e.f = 5'h1F;
        end
`endif
        return e;
    endfunction

    task automatic send(input logic [31:0] x, input exp_t e);
        @(negedge clk);
        in_r     = x;
        in_valid = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                last_e = exp_q.pop_front();
                check("result", 32'({out_digit, out_float, out_sign, out_ovf, out_nan}),
                      32'(last_e));
            end
        end
    end

    initial begin
        #2;
        check("reset_outs", 32'({out_digit, out_float, out_sign, out_ovf, out_nan, out_valid}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        send(32'h40B00000, mk(5'b00101, 5'b10000, 0, 0, 0));  // 5.5
        send(32'h3E200000, mk(5'b00000, 5'b00101, 0, 0, 0));  // 0.15625
        send(32'h3C000000, mk(5'b00000, 5'b00000, 0, 0, 0));  // 0.0078125
        send(32'hC0700000, mk(5'b00011, 5'b11000, 1, 0, 0));  // -3.75
        send(32'h80000000, mk(5'b00000, 5'b00000, 1, 0, 0));  // -0
        send(32'h42220000, mk(5'b01000, 5'b10000, 0, 1, 0));  // 40.5
        send(32'h7FC00000, mk(5'b00000, 5'b00000, 0, 0, 1));  // NaN
        send(32'h7F800000, mk(5'b00000, 5'b00000, 0, 1, 0));  // +inf
        send(32'hFF800000, mk(5'b00000, 5'b00000, 1, 1, 0));  // -inf
        send(32'hFFC00001, mk(5'b00000, 5'b00000, 1, 0, 1));  // -NaN
        send(32'h00000001, mk(5'b00000, 5'b00000, 0, 0, 0));  // denormal
        send(32'h3D000000, mk(5'b00000, 5'b00001, 0, 0, 0));  // 2^-5
        send(32'h3CFFFFFF, mk(5'b00000, 5'b00000, 0, 0, 0));  // just below 2^-5
        send(32'h41FF0000, mk(5'b11111, 5'b11100, 0, 0, 0));  // 31.875
        send(32'h42000000, mk(5'b00000, 5'b00000, 0, 1, 0));  // 32.0
        send(32'h4B800000, mk(5'b00000, 5'b00000, 0, 1, 0));  // 2^24
        send(32'h3F800000, mk(5'b00001, 5'b00000, 0, 0, 0));  // 1.0
        idle();
        @(posedge clk);
        #2;
        check("valid_low_idle", 32'(out_valid), 32'd0);
        check("hold_idle", 32'({out_digit, out_float}), 32'({last_e.d, last_e.f}));

        send(32'h40B00000, mk(5'b00101, 5'b10000, 0, 0, 0));
        send(32'h3E200000, mk(5'b00000, 5'b00101, 0, 0, 0));
        @(posedge clk);
        #2;
        check("b2b_valid", 32'(out_valid), 32'd1);

        // in-flight sample discarded by asynchronous reset before its edge
        @(negedge clk);
        in_r     = 32'h41FF0000;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'({out_digit, out_float, out_sign, out_ovf, out_nan, out_valid}), 32'd0);
        @(posedge clk);
        #2;
        check("rst_hold", 32'({out_digit, out_float, out_sign, out_ovf, out_nan, out_valid}), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        send(32'hC0700000, mk(5'b00011, 5'b11000, 1, 0, 0));
        idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ieee_to_binary.md
Name: ieee_to_binary

Overview:
- Converts a 32-bit IEEE-754 single-precision value into an unsigned fixed-point magnitude.
- The result has an INT_W-bit integer part (out_digit), an FRAC_W-bit fractional part (out_float) and a sign flag.
- Sits between floating-point operand sources and the fixed-point ALU datapath.
- Registered, one-cycle latency, valid-qualified.

Parameters:
- INT_W, 5, width of integer-part output out_digit.
- FRAC_W, 5, width of fractional-part output out_float.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in  input  32  IEEE-754 single: sign in[31], biased exponent in[30:23], mantissa in[22:0].
- in_valid  input  1  in is sampled on a clk edge when high.
- out_digit  output  INT_W  integer part of |x|.
- out_float  output  FRAC_W  fractional part of |x|, MSB = 2^-1.
- out_sign  output  1  copy of in[31].
- out_ovf  output  1  |x| >= 2^INT_W, or x is infinity.
- out_nan  output  1  x is NaN.
- out_valid  output  1  outputs correspond to the input accepted on the previous edge.

Behaviour:
- Reset (asynchronous, rst=1): all outputs go to 0 immediately and hold while rst is high.
- Conversion occurs on each rising clk edge with in_valid=1:
  - Let E = in[30:23] - 127.
  - Significand S = {1, in[22:0]}, i.e. value 1.m.
  - |x| = S * 2^E, truncated toward zero to FRAC_W fractional bits. No rounding.
- The conversion is purely combinational from in, registered once.
- Latency: outputs and out_valid=1 appear on the edge that samples in_valid=1.
- out_valid falls on the first edge with in_valid=0. Outputs hold their last value while out_valid=0.
- Back-to-back inputs are accepted every cycle. There is no backpressure.
- Field rules, applied in priority order:
  - exp=0 (zero or denormal): out_digit=0, out_float=0, out_ovf=0, out_nan=0. Denormals flush to zero. out_sign still reflects in[31], so -0 gives sign=1.
  - exp=255, mantissa≠0 (NaN): out_nan=1, out_ovf=0, out_digit=0, out_float=0.
  - exp=255, mantissa=0 (infinity): out_ovf=1, out_nan=0. out_digit and out_float follow the overflow rule below.
  - E < -FRAC_W: the value is below the fractional LSB, so out_digit=0 and out_float=0.
  - E >= INT_W: out_ovf=1. By default out_digit = integer part modulo 2^INT_W (wrap), and out_float = the truncated fraction bits. When E >= 23, out_float=0. For infinity both parts are 0.
  - Otherwise: out_ovf=0, and the exact truncated result is output.
- Sign handling: the sign never affects the magnitude fields. No two's complement conversion is done.
- Shifter: use a barrel shift of S sized to cover E in [-FRAC_W-1, INT_W+23]. Shift amounts outside that range produce zeros.
- Reset mid-operation: an asynchronous assertion discards the in-flight sample. The first valid output after release comes from the first in_valid=1 edge after release.

Optional Feature:
- Macro: IEEE_TO_BINARY_SATURATE_EN.
- Defined: whenever out_ovf=1 (including infinity), out_digit is forced to all ones and out_float is forced to all ones (max representable 31.96875 at default widths).
- Not defined: the wrap behaviour described above.
- out_ovf, out_nan and out_sign are identical in both builds.

Test Plan:
- Reset, then in=0x40B00000 (5.5) with in_valid=1 -> next edge: out_digit=00101, out_float=10000, sign=0, ovf=0, nan=0, out_valid=1.
- in=0x3E200000 (0.15625) -> out_digit=00000, out_float=00101. Then in=0x3C000000 (0.0078125) -> digit=0, float=0.
- in=0xC0700000 (-3.75) -> sign=1, out_digit=00011, out_float=11000. Then in=0x80000000 (-0) -> sign=1, digit=0, float=0.
- in=0x42220000 (40.5) -> ovf=1:
  - default build: out_digit=01000, out_float=10000.
  - with SATURATE_EN: out_digit=11111, out_float=11111.
- in=0x7FC00000 (NaN) -> nan=1, digit=0, float=0. in=0x7F800000 (+inf) -> ovf=1, nan=0.
- Back-to-back 5.5 then 0.15625 on consecutive cycles -> consecutive correct outputs, out_valid high both cycles. Assert rst mid-stream -> all outputs 0 immediately without waiting for a clk edge.
